// File: rtl/uart_rx_configurable.sv
// Configurable UART receiver: 2-flop input synchroniser, 3-sample majority vote per bit,
// 5..9 data bits, optional odd/even parity, 1 or 2 stop bits, parity/framing/break reporting.

module uart_rx_configurable #(
  parameter int unsigned SYS_CLK_FREQ = 48_000_000,
  parameter int unsigned BAUD_RATE    = 9_600,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int unsigned BIT_PERIOD = SYS_CLK_FREQ / BAUD_RATE;
  localparam int unsigned MID        = BIT_PERIOD / 2;
  localparam int unsigned TW         = $clog2(BIT_PERIOD);
  localparam int unsigned CW         = 4;

  localparam logic [TW-1:0] T_S0  = TW'(MID - 1);
  localparam logic [TW-1:0] T_S1  = TW'(MID);
  localparam logic [TW-1:0] T_RES = TW'(MID + 1);
  localparam logic [TW-1:0] T_END = TW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t               state, state_nxt;
  logic                 sync1, rx_s, rx_d;
  logic [TW-1:0]        timer, timer_nxt;
  logic [CW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [1:0]           samp, samp_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 pbit, pbit_nxt;
  logic                 perr, perr_nxt;
  logic                 ferr, ferr_nxt;
  logic [DATA_BITS-1:0] data_out_nxt;
  logic                 data_valid_nxt, parity_err_nxt, frame_err_nxt, break_det_nxt;

  logic maj, exp_par, stop_ferr, is_break;

  // Third sample is the live rx_s at the resolve point
  assign maj       = (samp[0] & samp[1]) | (rx_s & (samp[0] | samp[1]));
  assign exp_par   = (PARITY == 1) ? ~(^shreg) : (^shreg);
  assign stop_ferr = ferr | ~maj;
  assign is_break  = (shreg == '0) && ((PARITY == 0) || !pbit) && stop_ferr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      state      <= S_IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      samp       <= '0;
      shreg      <= '0;
      pbit       <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      sync1      <= rx;
      rx_s       <= sync1;
      rx_d       <= rx_s;
      state      <= state_nxt;
      timer      <= timer_nxt;
      bit_cnt    <= bit_cnt_nxt;
      samp       <= samp_nxt;
      shreg      <= shreg_nxt;
      pbit       <= pbit_nxt;
      perr       <= perr_nxt;
      ferr       <= ferr_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      parity_err <= parity_err_nxt;
      frame_err  <= frame_err_nxt;
      break_det  <= break_det_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    bit_cnt_nxt    = bit_cnt;
    samp_nxt       = samp;
    shreg_nxt      = shreg;
    pbit_nxt       = pbit;
    perr_nxt       = perr;
    ferr_nxt       = ferr;
    data_out_nxt   = data_out;
    data_valid_nxt = 1'b0;
    parity_err_nxt = parity_err;
    frame_err_nxt  = frame_err;
    break_det_nxt  = 1'b0;

    if (state != S_IDLE && state != S_WAIT_IDLE) begin
      timer_nxt = (timer == T_END) ? '0 : timer + TW'(1);
      if (timer == T_S0) samp_nxt[0] = rx_s;
      if (timer == T_S1) samp_nxt[1] = rx_s;
    end

    case (state)
      S_IDLE: begin
        timer_nxt = '0;
        if (rx_d && !rx_s) begin
          state_nxt = S_START;
          perr_nxt  = 1'b0;
          ferr_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (timer == T_RES && maj) begin
          state_nxt = S_IDLE;
          timer_nxt = '0;
        end else if (timer == T_END) begin
          state_nxt   = S_DATA;
          bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (timer == T_RES) shreg_nxt = {maj, shreg[DATA_BITS-1:1]};
        if (timer == T_END) begin
          bit_cnt_nxt = bit_cnt + CW'(1);
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_nxt = '0;
            state_nxt   = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (timer == T_RES) begin
          pbit_nxt = maj;
          perr_nxt = (maj != exp_par);
        end
        if (timer == T_END) begin
          state_nxt   = S_STOP;
          bit_cnt_nxt = '0;
        end
      end
      S_STOP: begin
        // The last stop bit completes the frame right after its resolve point
        if (timer == T_RES) begin
          ferr_nxt = stop_ferr;
          if (bit_cnt == LAST_STOP) begin
            timer_nxt = '0;
            if (is_break) begin
              break_det_nxt = 1'b1;
              state_nxt     = S_WAIT_IDLE;
            end else begin
              data_valid_nxt = 1'b1;
              data_out_nxt   = shreg;
              parity_err_nxt = perr;
              frame_err_nxt  = stop_ferr;
              state_nxt      = stop_ferr ? S_WAIT_IDLE : S_IDLE;
            end
          end
        end else if (timer == T_END) begin
          bit_cnt_nxt = bit_cnt + CW'(1);
        end
      end
      S_WAIT_IDLE: begin
        timer_nxt = '0;
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
